e203_clkgate_ctrl: RTL and testbench
====================================

Name: e203_clkgate_ctrl

Overview:
- Always-on controller that generates `clock_en` for one e203_clkgate cell.
- Gates the downstream clock after a programmable run of consecutive idle cycles.
- Restores the clock on activity, wake request, policy change or test mode, then holds off `clk_ready` for a settle window.
- Runs on the ungated clock; the owning unit's gated domain consumes `clk_ready`/`gated` status.

Parameters:
- IDLE_CYCLES, 16: consecutive idle cycles required before gating; legal range 1..255.
- WAKE_CYCLES, 2: settle cycles after re-enable before `clk_ready`; 0 allowed.
- CNT_W, 16: width of the saturating gate-event counter.

Ports:
- clk  in  1  ungated free-running clock.
- rst  in  1  synchronous, active-high reset.
- busy  in  1  downstream unit active; blocks or ends gating.
- wake_req  in  1  external request to restore the gated clock.
- sleep_allow  in  1  software policy enable for gating.
- test_mode  in  1  scan/test mode; forces clock on.
- clock_en  out  1  enable to the gate cell.
- clk_ready  out  1  gated clock stable; requester may proceed.
- gated  out  1  status: clock currently gated or waking.
- gate_cnt  out  CNT_W  saturating count of gating events.

Behaviour:
- Reset values (on the edge where rst=1, from any state including mid-WAKE):
  - state=RUN, clock_en=1, clk_ready=1, gated=0.
  - idle_cnt=0, wake_cnt=0, gate_cnt=0.
- idle = sleep_allow & ~busy & ~wake_req & ~test_mode, sampled each rising clk.
- clock_en = en_r | test_mode.
  - The test_mode OR is combinational; en_r, clk_ready and gated are registered.
- States:
  - RUN (en_r=1, clk_ready=1, gated=0):
    - idle & IDLE_CYCLES==1 -> GATED.
    - idle -> COUNT, idle_cnt=1.
    - otherwise stay, idle_cnt=0.
  - COUNT (outputs as RUN):
    - ~idle -> RUN, idle_cnt=0.
    - idle & idle_cnt==IDLE_CYCLES-1 -> GATED.
    - otherwise idle_cnt+1.
  - GATED (en_r=0, clk_ready=0, gated=1):
    - any of busy | wake_req | ~sleep_allow | test_mode -> WAKE (or RUN if WAKE_CYCLES==0).
    - On that transition en_r=1 and wake_cnt=0.
  - WAKE (en_r=1, clk_ready=0, gated=1):
    - wake_cnt increments each cycle.
    - At wake_cnt==WAKE_CYCLES-1 -> RUN; clk_ready=1 and gated=0 take effect after that edge.
    - Idle is ignored in WAKE; re-gating requires passing through RUN.
- Gating latency:
  - Idle sampled at N consecutive edges, N=IDLE_CYCLES.
  - en_r falls after the Nth edge.
  - Any non-idle sample restarts the count from zero.
- Wake latency:
  - clock_en rises on the first edge sampling the wake condition.
  - clk_ready rises WAKE_CYCLES edges later.
- gate_cnt:
  - +1 on every RUN/COUNT->GATED transition.
  - Saturates at 2^CNT_W-1, no wrap.
- Simultaneous events:
  - In GATED, busy and wake_req together count as one wake.
  - rst has priority over all transitions.
- A wake_req pulse of a single cycle is sufficient; no level hold is required.

Test Plan (IDLE_CYCLES=4, WAKE_CYCLES=2 unless stated):
- Reset: rst=1 for 2 edges, then 0 -> clock_en=1, clk_ready=1, gated=0, gate_cnt=0.
- Gate entry: sleep_allow=1, busy=0 from edge e1 -> clock_en=1 after e3, clock_en=0/gated=1/clk_ready=0/gate_cnt=1 after e4.
- Interrupted idle: 3 idle edges, busy=1 at the 4th, then idle again -> no gating until 4 fresh idle edges; gate_cnt stays 0 until then.
- Wake: in GATED, 1-cycle wake_req at edge w -> clock_en=1 after w, clk_ready=0 after w and w+1, clk_ready=1/gated=0 after w+2.
- Test mode: in GATED, raise test_mode -> clock_en=1 immediately (combinational), state WAKE then RUN; with test_mode held and busy=0, clock_en never falls.
- Saturation and reset: CNT_W=2, 5 gate/wake cycles -> gate_cnt=3 held; assert rst during WAKE -> next edge RUN, clk_ready=1, gate_cnt=0.

Source files
------------

// File: rtl/e203_clkgate_ctrl.sv
// Always-on clock-gate controller: drops clock_en after IDLE_CYCLES consecutive idle
// samples and restores it on activity, holding clk_ready low for WAKE_CYCLES.
module e203_clkgate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             wake_req,
    input  logic             sleep_allow,
    input  logic             test_mode,
    output logic             clock_en,
    output logic             clk_ready,
    output logic             gated,
    output logic [CNT_W-1:0] gate_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_LAST = 8'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);

    state_t           state_reg;
    logic [7:0]       idle_cnt_reg;
    logic [7:0]       wake_cnt_reg;
    logic [CNT_W-1:0] gate_cnt_reg;
    logic             en_reg;
    logic             ready_reg;
    logic             gated_reg;

    logic idle;
    logic wake_cond;
    logic cnt_full;

    assign idle      = sleep_allow & ~busy & ~wake_req & ~test_mode;
    assign wake_cond = busy | wake_req | ~sleep_allow | test_mode;
    assign cnt_full  = &gate_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            idle_cnt_reg <= '0;
            wake_cnt_reg <= '0;
            gate_cnt_reg <= '0;
            en_reg       <= 1'b1;
            ready_reg    <= 1'b1;
            gated_reg    <= 1'b0;
        end else begin
            case (state_reg)
                RUN, COUNT: begin
                    // Enter GATED once the run of idle samples reaches IDLE_CYCLES;
                    // IDLE_CYCLES==1 gates straight from RUN.
                    if (idle && (IDLE_CYCLES == 1 || (state_reg == COUNT && idle_cnt_reg == IDLE_LAST))) begin
                        state_reg    <= GATED;
                        idle_cnt_reg <= '0;
                        en_reg       <= 1'b0;
                        ready_reg    <= 1'b0;
                        gated_reg    <= 1'b1;
                        if (!cnt_full)
                            gate_cnt_reg <= gate_cnt_reg + CNT_W'(1);
                    end else if (idle) begin
                        state_reg    <= COUNT;
                        idle_cnt_reg <= (state_reg == RUN) ? 8'd1 : idle_cnt_reg + 8'd1;
                    end else begin
                        state_reg    <= RUN;
                        idle_cnt_reg <= '0;
                    end
                end
                GATED: begin
                    if (wake_cond) begin
                        en_reg       <= 1'b1;
                        wake_cnt_reg <= '0;
                        if (WAKE_CYCLES == 0) begin
                            state_reg <= RUN;
                            ready_reg <= 1'b1;
                            gated_reg <= 1'b0;
                        end else begin
                            state_reg <= WAKE;
                        end
                    end
                end
                WAKE: begin
                    // Settle window; idle is deliberately ignored here.
                    if (wake_cnt_reg == WAKE_LAST) begin
                        state_reg    <= RUN;
                        wake_cnt_reg <= '0;
                        ready_reg    <= 1'b1;
                        gated_reg    <= 1'b0;
                    end else begin
                        wake_cnt_reg <= wake_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= RUN;
                    en_reg    <= 1'b1;
                    ready_reg <= 1'b1;
                    gated_reg <= 1'b0;
                end
            endcase
        end
    end

    assign clock_en  = en_reg | test_mode;
    assign clk_ready = ready_reg;
    assign gated     = gated_reg;
    assign gate_cnt  = gate_cnt_reg;

endmodule

// File: tb/tb_e203_clkgate_ctrl.sv
// Directed bench for e203_clkgate_ctrl: main instance (IDLE=4, WAKE=2, CNT_W=2)
// plus a boundary instance (IDLE=1, WAKE=0) sharing the same inputs.
module tb_e203_clkgate_ctrl;

    logic clk = 1'b0;
    logic rst, busy, wake_req, sleep_allow, test_mode;

    logic       clock_en, clk_ready, gated;
    logic [1:0] gate_cnt;
    logic        f_clock_en, f_clk_ready, f_gated;
    logic [15:0] f_gate_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    e203_clkgate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .busy(busy), .wake_req(wake_req),
        .sleep_allow(sleep_allow), .test_mode(test_mode),
        .clock_en(clock_en), .clk_ready(clk_ready), .gated(gated), .gate_cnt(gate_cnt)
    );

    e203_clkgate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0), .CNT_W(16)) u_fast (
        .clk(clk), .rst(rst), .busy(busy), .wake_req(wake_req),
        .sleep_allow(sleep_allow), .test_mode(test_mode),
        .clock_en(f_clock_en), .clk_ready(f_clk_ready), .gated(f_gated), .gate_cnt(f_gate_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", tag, obs, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic en, input logic rdy,
                              input logic g, input logic [1:0] cnt);
        check({tag, ".clock_en"},  {31'd0, clock_en},  {31'd0, en});
        check({tag, ".clk_ready"}, {31'd0, clk_ready}, {31'd0, rdy});
        check({tag, ".gated"},     {31'd0, gated},     {31'd0, g});
        check({tag, ".gate_cnt"},  {30'd0, gate_cnt},  {30'd0, cnt});
    endtask

    task automatic wake_pulse();
        wake_req = 1'b1;
        step();
        wake_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; busy = 1'b1; wake_req = 1'b0; sleep_allow = 1'b0; test_mode = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_main("reset", 1'b1, 1'b1, 1'b0, 2'd0);
        check("reset.fast_cnt", {16'd0, f_gate_cnt}, 32'd0);

        // Gate entry: idle from e1, gates after e4
        busy = 1'b0; sleep_allow = 1'b1;
        step();
        check("e1.fast_clock_en", {31'd0, f_clock_en}, 32'd0);
        check("e1.fast_gate_cnt", {16'd0, f_gate_cnt}, 32'd1);
        check_main("e1", 1'b1, 1'b1, 1'b0, 2'd0);
        step();
        step();
        check_main("e3", 1'b1, 1'b1, 1'b0, 2'd0);
        step();
        check_main("e4", 1'b0, 1'b0, 1'b1, 2'd1);

        // Single-cycle wake request
        wake_req = 1'b1;
        step();
        wake_req = 1'b0;
        check_main("w", 1'b1, 1'b0, 1'b1, 2'd1);
        check("w.fast_ready", {31'd0, f_clk_ready}, 32'd1);
        check("w.fast_gated", {31'd0, f_gated}, 32'd0);
        step();
        check_main("w+1", 1'b1, 1'b0, 1'b1, 2'd1);
        check("w+1.fast_gate_cnt", {16'd0, f_gate_cnt}, 32'd2);
        step();
        check_main("w+2", 1'b1, 1'b1, 1'b0, 2'd1);

        // Interrupted idle: 3 idle edges, busy on the 4th, then 4 fresh idle edges
        step();
        step();
        step();
        busy = 1'b1;
        step();
        busy = 1'b0;
        check_main("intr.busy", 1'b1, 1'b1, 1'b0, 2'd1);
        step();
        step();
        step();
        check_main("intr.j3", 1'b1, 1'b1, 1'b0, 2'd1);
        step();
        check_main("intr.j4", 1'b0, 1'b0, 1'b1, 2'd2);

        // Test mode forces the clock on combinationally, then walks WAKE -> RUN
        test_mode = 1'b1;
        #1;
        check("tm.comb_clock_en", {31'd0, clock_en}, 32'd1);
        check("tm.comb_gated", {31'd0, gated}, 32'd1);
        step();
        check_main("tm.t1", 1'b1, 1'b0, 1'b1, 2'd2);
        step();
        check_main("tm.t2", 1'b1, 1'b0, 1'b1, 2'd2);
        step();
        check_main("tm.t3", 1'b1, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 8; i++) begin
            step();
            check("tm.hold_clock_en", {31'd0, clock_en}, 32'd1);
        end
        test_mode = 1'b0;

        // Gate/wake cycles: counter saturates at 3
        for (int k = 3; k <= 5; k++) begin
            repeat (4) step();
            check_main("sat.gated", 1'b0, 1'b0, 1'b1, 2'd3);
            if (k < 5) wake_pulse();
        end

        // Reset in the middle of WAKE
        wake_req = 1'b1;
        step();
        wake_req = 1'b0;
        check_main("rstwake.pre", 1'b1, 1'b0, 1'b1, 2'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_main("rstwake.post", 1'b1, 1'b1, 1'b0, 2'd0);
        check("rstwake.fast_cnt", {16'd0, f_gate_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
